// File: rtl/uart_pkg.sv
// Shared UART definitions: receive bit-FSM states and baud divider helper.
// Used by both the receive and transmit halves of the UART word path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clock cycles per bit time, rounded down.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: 2-flop synchroniser, start/data/stop bit FSM and
// baud counter. Emits one-cycle byte_valid / stop_err at the mid-stop sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int WORD_PART    = 8,
    parameter int CLKS_PER_BIT = 1736
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sig_in,
    output logic                 byte_valid,
    output logic [WORD_PART-1:0] byte_data,
    output logic                 stop_err,
    output logic                 start_det,
    output logic                 rx_idle
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_W    = (WORD_PART > 1) ? $clog2(WORD_PART) : 1;

    // line_q[0]: first sync stage, [1]: synchronised line, [2]: previous synchronised value.
    logic [2:0]           line_q, line_d;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [WORD_PART-1:0] shift_q, shift_d;

    logic rx_bit;
    logic fall;

    assign rx_bit    = line_q[1];
    assign fall      = line_q[2] & ~line_q[1];
    assign byte_data = shift_q;
    assign rx_idle   = (state_q == IDLE);

    // Register the synchroniser chain, FSM state, baud counter and shift register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_q    <= 3'b111;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            line_q    <= line_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: detect start, verify it at half-bit, sample data and stop at mid-bit.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        line_d     = {line_q[1:0], sig_in};
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        start_det  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    start_det = 1'b1;
                    state_d   = START;
                    cnt_d     = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A line that is high again at half-bit was a glitch.
                    state_d   = rx_bit ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_bit, shift_q[WORD_PART-1:1]};
                    if (bit_idx_q == BIT_W'(WORD_PART - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    // Return at mid-stop so the next start edge is seen without dead time.
                    cnt_d      = '0;
                    state_d    = IDLE;
                    byte_valid = rx_bit;
                    stop_err   = ~rx_bit;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_word_rx.sv
// UART receive word path: packs WORD_SIZE/WORD_PART bytes (first byte in the LSBs)
// and pushes each word into the receive FIFO, flagging framing errors,
// overruns and inter-byte timeouts as single-cycle pulses.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int WORD_PART    = 8,
    parameter int CLQ_FREQ     = 200_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 full,
    output logic                 w_enable,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 timeout
);

    localparam int CPB       = clks_per_bit(CLQ_FREQ, BAUD_RATE);
    localparam int BYTES     = WORD_SIZE / WORD_PART;
    localparam int IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TMO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    logic                 byte_valid;
    logic [WORD_PART-1:0] byte_data;
    logic                 stop_err;
    logic                 start_det;
    logic                 rx_idle;

    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 w_enable_q, w_enable_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 timeout_q, timeout_d;

    uart_rx_byte #(
        .WORD_PART    (WORD_PART),
        .CLKS_PER_BIT (CPB)
    ) u_rx_byte (
        .clock      (clock),
        .reset      (reset),
        .sig_in     (sig_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err),
        .start_det  (start_det),
        .rx_idle    (rx_idle)
    );

    assign w_enable  = w_enable_q;
    assign data_out  = data_out_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

    // Register packing state, timeout counter and the registered output pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx_q  <= '0;
            word_q      <= '0;
            data_out_q  <= '0;
            tmo_cnt_q   <= '0;
            w_enable_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            data_out_q  <= data_out_d;
            tmo_cnt_q   <= tmo_cnt_d;
            w_enable_q  <= w_enable_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Pack bytes, decide push vs overrun on word completion, and run the inter-byte timeout.
    always_comb begin
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        data_out_d  = data_out_q;
        tmo_cnt_d   = tmo_cnt_q;
        w_enable_d  = 1'b0;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;

        if (byte_valid) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_idx_q == IDX_W'(b)) begin
                    word_d[b*WORD_PART +: WORD_PART] = byte_data;
                end
            end
            if (byte_idx_q == IDX_W'(BYTES - 1)) begin
                byte_idx_d = '0;
                if (full) begin
                    overrun_d = 1'b1;
                end else begin
                    w_enable_d = 1'b1;
                    data_out_d = word_d;
                end
            end else begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
            end
        end else if (stop_err) begin
            // Drop the byte and resynchronise on a word boundary.
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
        end

        // Idle-time watchdog on a partially assembled word; byte_valid/stop_err
        // only occur outside IDLE, so this never overlaps the pulses above.
        if (start_det || byte_idx_q == '0) begin
            tmo_cnt_d = '0;
        end else if (rx_idle) begin
            if (tmo_cnt_q == TMO_W'(TMO_LIMIT - 1)) begin
                timeout_d  = 1'b1;
                byte_idx_d = '0;
                tmo_cnt_d  = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx: drives 8N1 frames, queues the expected
// pulse for each word/error and compares when the DUT raises a pulse.
// A short bit time keeps the run small while preserving all timing relations.
module tb_uart_word_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    typedef enum int { EV_PUSH = 1, EV_OVR = 2, EV_FERR = 3, EV_TMO = 4 } ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] data;
        bit          lat;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sig_in = 1'b1;
    logic        full = 1'b0;
    logic        w_enable;
    logic [31:0] data_out;
    logic        frame_err;
    logic        overrun;
    logic        timeout;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint last_stop = 0;
    ev_t    exp_q[$];

    uart_word_rx #(
        .WORD_SIZE    (32),
        .WORD_PART    (8),
        .CLQ_FREQ     (1_600_000),
        .BAUD_RATE    (100_000),
        .TIMEOUT_BITS (40)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .full      (full),
        .w_enable  (w_enable),
        .data_out  (data_out),
        .frame_err (frame_err),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic bit_time(input logic v);
        sig_in = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        last_stop = cyc;
        bit_time(stop_v);
        if (!stop_v) bit_time(1'b1);
        sig_in = 1'b1;
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [31:0] data, input bit lat);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 3; b++) send_byte(w[8*b +: 8]);
        expect_ev(EV_PUSH, w, 1'b1);
        send_byte(w[31:24]);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            @(negedge clock);
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Scoreboard side: compare every pulse against the oldest expectation.
    initial begin
        int     n;
        int     obs;
        longint dt;
        ev_t    e;
        forever begin
            @(posedge clock);
            #1;
            n = int'(w_enable) + int'(overrun) + int'(frame_err) + int'(timeout);
            if (n != 0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", n, 0);
                end else begin
                    check("one_hot", n, 1);
                    obs = w_enable ? EV_PUSH : overrun ? EV_OVR : frame_err ? EV_FERR : EV_TMO;
                    e = exp_q.pop_front();
                    check("event_kind", obs, e.kind);
                    if (e.kind == EV_PUSH) check("data_out", data_out, e.data);
                    if (e.lat) begin
                        dt = cyc - last_stop;
                        check("stop_latency", (dt >= HALF && dt < CPB), 1);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_w_enable", w_enable, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_data_out", data_out, 0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);

        // Plain word.
        send_word(32'h12345678);
        drain("t1_drain");

        // Short low glitch in the middle of a word must change nothing.
        send_byte(8'h21);
        send_byte(8'h43);
        sig_in = 1'b0;
        repeat (4) @(negedge clock);
        sig_in = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        send_byte(8'h65);
        expect_ev(EV_PUSH, 32'h87654321, 1'b1);
        send_byte(8'h87);
        drain("t2_drain");

        // Framing error, then word resynchronises from byte 0.
        expect_ev(EV_FERR, 32'h0, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_word(32'h04030201);
        drain("t3_drain");

        // Overrun while FIFO full; data_out keeps the previous word.
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        full = 1'b1;
        expect_ev(EV_OVR, 32'h0, 1'b1);
        send_byte(8'hEF);
        drain("t4_drain");
        check("t4_data_hold", data_out, 32'h04030201);
        full = 1'b0;
        send_word(32'hCAFEF00D);
        drain("t4b_drain");

        // Inter-byte timeout discards the partial word.
        send_byte(8'h11);
        send_byte(8'h22);
        expect_ev(EV_TMO, 32'h0, 1'b0);
        repeat (40 * CPB + 10) @(negedge clock);
        drain("t5_drain");
        send_word(32'h04030201);
        drain("t5b_drain");

        // Reset in the middle of byte 2 of a word.
        send_byte(8'h01);
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(1'b1);
        reset = 1'b1;
        #1;
        check("t6_w_enable", w_enable, 0);
        check("t6_overrun", overrun, 0);
        check("t6_frame_err", frame_err, 0);
        check("t6_timeout", timeout, 0);
        check("t6_data_out", data_out, 0);
        sig_in = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);
        send_word(32'h04030201);
        drain("t6_drain");

        repeat (2 * CPB) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
